// File: rtl/byte_unstriping_pkg.sv
// byte_unstriping_pkg: shared state encoding and default lane geometry, reused by the striping RX block.
package byte_unstriping_pkg;
  localparam int BU_DATA_W = 8;
  localparam int BU_LANES = 4;
  typedef enum logic {BU_IDLE = 1'b0, BU_STREAM = 1'b1} bu_state_e;
endpackage

// File: rtl/byte_unstriping_fifo.sv
// lane_fifo: per-lane synchronous FIFO; a push into a full FIFO only lands when a pop frees a slot that cycle.
module lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        din_i,
  output logic [DATA_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/byte_unstriping.sv
// byte_unstriping: merges LANES byte lanes back into one stream, lane0 first, only in complete rounds.
// Define BYTE_UNSTRIPE_ERR_EN to get sticky per-lane overflow flags on OVF_ERR.
module byte_unstriping
  import byte_unstriping_pkg::*;
#(
  parameter int DATA_W = BU_DATA_W,
  parameter int LANES = BU_LANES,
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [LANES*DATA_W-1:0] LANE_DATA,
  input  logic [LANES-1:0]        LANE_VALID,
  output logic [DATA_W-1:0]       DATA,
  output logic                    VALID_OUT,
  output logic [LANES-1:0]        OVF_ERR
);
  localparam int SW = $clog2(LANES);
  localparam int CW = $clog2(DEPTH) + 1;
  bu_state_e state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic [LANES-1:0] pop, full, empty;
  logic [DATA_W-1:0] head [LANES];
  logic [CW-1:0] cnt [LANES];
  logic all_rdy, next_rdy, last;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(CLK), .rst(RESET), .push_i(LANE_VALID[g]), .pop_i(pop[g]),
      .din_i(LANE_DATA[g*DATA_W +: DATA_W]), .head_o(head[g]), .count_o(cnt[g]),
      .full_o(full[g]), .empty_o(empty[g])
    );
    assign pop[g] = state_q == BU_STREAM && sel_q == SW'(g);
  end
  assign all_rdy = ~|empty;
  assign last = sel_q == SW'(LANES - 1);
  // The last lane is still being popped when the next round is judged, so it needs a second byte.
  always_comb begin
    next_rdy = 1'b1;
    for (int i = 0; i < LANES; i++)
      next_rdy &= (i == LANES - 1) ? (cnt[i] >= CW'(2)) : (cnt[i] != '0);
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    data_d = data_q;
    valid_d = 1'b0;
    if (state_q == BU_IDLE) begin
      state_d = all_rdy ? BU_STREAM : BU_IDLE;
      sel_d = '0;
    end else begin
      data_d = head[sel_q];
      valid_d = 1'b1;
      sel_d = last ? '0 : sel_q + SW'(1);
      state_d = (!last || next_rdy) ? BU_STREAM : BU_IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= BU_IDLE;
      sel_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
  assign DATA = data_q;
  assign VALID_OUT = valid_q;
`ifdef BYTE_UNSTRIPE_ERR_EN
  logic [LANES-1:0] ovf_q;
  always_ff @(posedge CLK)
    ovf_q <= RESET ? '0 : ovf_q | (LANE_VALID & full & ~pop);
  assign OVF_ERR = ovf_q;
`else
  logic unused_full;
  assign unused_full = ^full;
  assign OVF_ERR = '0;
`endif
endmodule

// File: tb/tb_byte_unstriping.sv
// tb_byte_unstriping: vector table plus corner sequences; a negedge monitor checks every output byte against a scoreboard.
module tb_byte_unstriping;
  typedef struct {logic [7:0] d; int e;} exp_t;
  typedef struct {logic [31:0] d; int sl; int sk;} vec_t;
`ifdef BYTE_UNSTRIPE_ERR_EN
  localparam logic [3:0] OVF_EXP = 4'b0010;
`else
  localparam logic [3:0] OVF_EXP = 4'b0000;
`endif
  logic clk = 1'b0, rst;
  logic [31:0] ld;
  logic [3:0] lv;
  logic [7:0] data;
  logic vout;
  logic [3:0] ovf;
  int edge_n = 0, checks = 0, errors = 0;
  exp_t q[$];
  exp_t cur;
  vec_t tbl[4];
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  byte_unstriping dut (
    .CLK(clk), .RESET(rst), .LANE_DATA(ld), .LANE_VALID(lv),
    .DATA(data), .VALID_OUT(vout), .OVF_ERR(ovf)
  );
  always @(negedge clk) begin
    if (vout) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got %0h at edge %0d, expected no output", data, edge_n);
      end else begin
        cur = q.pop_front();
        if (data !== cur.d || (cur.e >= 0 && edge_n != cur.e)) begin
          errors++;
          $display("FAIL stream_byte: got %0h at edge %0d, expected %0h at edge %0d", data, edge_n, cur.d, cur.e);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic strobe(input logic [3:0] m, input logic [31:0] d, output int t);
    lv = m;
    ld = d;
    @(posedge clk);
    #1;
    t = edge_n;
    lv = '0;
  endtask
  task automatic expect_b(input logic [7:0] d, input int e);
    q.push_back('{d, e});
  endtask
  function automatic logic [7:0] bv(input int r, input int i);
    return 8'(8'h80 + 16 * r + i);
  endfunction
  task automatic run_vec(input vec_t v);
    int t;
    logic [3:0] m;
    m = v.sk > 0 ? 4'hF & ~(4'b1 << v.sl) : 4'hF;
    strobe(m, v.d, t);
    if (v.sk > 0) begin
      idle(v.sk - 1);
      strobe(4'b1 << v.sl, v.d, t);
    end
    for (int k = 0; k < 4; k++) expect_b(v.d[8*k +: 8], t + 2 + k);
    idle(8);
    chk("vec_drain", q.size(), 0);
  endtask
  initial begin
    int t, s;
    tbl[0] = '{32'hA3A2A1A0, 0, 0};
    tbl[1] = '{32'h33221100, 2, 3};
    tbl[2] = '{32'hFF00FF00, 0, 2};
    tbl[3] = '{32'h80017F10, 3, 1};
    rst = 1'b1;
    lv = '0;
    ld = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", vout, 0);
    chk("rst_data", data, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    idle(1);
    for (int v = 0; v < 4; v++) run_vec(tbl[v]);
    // back-to-back: three rounds, twelve consecutive outputs
    for (int r = 0; r < 3; r++) strobe(4'b0111, {8'h00, bv(r, 2), bv(r, 1), bv(r, 0)}, t);
    strobe(4'b1000, {bv(0, 3), 24'h0}, s);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) expect_b(bv(r, i), s + 2 + 4 * r + i);
    for (int r = 1; r < 3; r++) strobe(4'b1000, {bv(r, 3), 24'h0}, t);
    idle(16);
    chk("b2b_drain", q.size(), 0);
    // reset right after lane1's byte leaves
    strobe(4'hF, 32'h44332211, t);
    expect_b(8'h11, t + 2);
    expect_b(8'h22, t + 3);
    idle(3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", vout, 0);
    chk("midrst_data", data, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(8);
    chk("midrst_drain", q.size(), 0);
    run_vec(tbl[0]);
    // overflow: five pushes on lane1 with the other lanes empty
    for (int i = 0; i < 5; i++) strobe(4'b0010, {16'h0, 8'(8'h50 + i), 8'h00}, t);
    chk("ovf_flag", ovf, OVF_EXP);
    for (int k = 0; k < 4; k++) begin
      expect_b(8'(8'hC0 + k), -1);
      expect_b(8'(8'h50 + k), -1);
      expect_b(8'(8'hD0 + k), -1);
      expect_b(8'(8'hE0 + k), -1);
    end
    for (int k = 0; k < 4; k++) strobe(4'b1101, {8'(8'hE0 + k), 8'(8'hD0 + k), 8'h00, 8'(8'hC0 + k)}, t);
    idle(24);
    chk("ovf_drain", q.size(), 0);
    chk("ovf_sticky", ovf, OVF_EXP);
    rst = 1'b1;
    idle(1);
    chk("ovf_cleared", ovf, 0);
    rst = 1'b0;
    idle(1);
    // full lane0 popped and pushed in the same cycle
    for (int i = 0; i < 4; i++) strobe(4'b0001, {24'h0, 8'(8'h60 + i)}, t);
    strobe(4'b1110, 32'h73727100, t);
    expect_b(8'h60, t + 2);
    expect_b(8'h71, t + 3);
    expect_b(8'h72, t + 4);
    expect_b(8'h73, t + 5);
    idle(1);
    strobe(4'b0001, 32'h00000064, s);
    for (int k = 1; k < 5; k++) begin
      expect_b(8'(8'h60 + k), -1);
      expect_b(8'(16 * k + 1), -1);
      expect_b(8'(16 * k + 2), -1);
      expect_b(8'(16 * k + 3), -1);
    end
    for (int k = 1; k < 5; k++) strobe(4'b1110, {8'(16 * k + 3), 8'(16 * k + 2), 8'(16 * k + 1), 8'h00}, t);
    idle(24);
    chk("fullpop_drain", q.size(), 0);
    chk("fullpop_ovf", ovf, 0);
    idle(4);
    chk("final_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
